// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit with HI/LO registers: single-cycle multiply, 32-step restoring divide.
// Optional multiply-accumulate (MADD/MADDU/MSUB/MSUBU) is enabled by defining MULDIV_MACC_EN.
module hilo_muldiv #(
  parameter logic [31:0] HI_RST = 32'h0,
  parameter logic [31:0] LO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  alucontrolE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        enE,
  input  logic        flushE,
  output logic        stall_divE,
  output logic [31:0] resultE,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] MFHI_CONTROL  = 8'h10;
  localparam logic [7:0] MTHI_CONTROL  = 8'h11;
  localparam logic [7:0] MFLO_CONTROL  = 8'h12;
  localparam logic [7:0] MTLO_CONTROL  = 8'h13;
  localparam logic [7:0] MULT_CONTROL  = 8'h18;
  localparam logic [7:0] MULTU_CONTROL = 8'h19;
  localparam logic [7:0] DIV_CONTROL   = 8'h1a;
  localparam logic [7:0] DIVU_CONTROL  = 8'h1b;
  localparam logic [7:0] MUL_CONTROL   = 8'h1c;
`ifdef MULDIV_MACC_EN
  localparam logic [7:0] MADD_CONTROL  = 8'h20;
  localparam logic [7:0] MADDU_CONTROL = 8'h21;
  localparam logic [7:0] MSUB_CONTROL  = 8'h24;
  localparam logic [7:0] MSUBU_CONTROL = 8'h25;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [31:0] hi, lo;
  logic [4:0]  count;
  logic [31:0] div_q, div_r, div_b;
  logic        neg_q, neg_r;

  logic        commit, is_div, div_signed;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, q_final, r_final;
  logic [32:0] shifted, trial;

  assign commit     = enE & ~flushE;
  assign div_signed = (alucontrolE == DIV_CONTROL);
  assign is_div     = div_signed | (alucontrolE == DIVU_CONTROL);

  assign prod_s = $signed({{32{srcaE[31]}}, srcaE}) * $signed({{32{srcbE[31]}}, srcbE});
  assign prod_u = {32'h0, srcaE} * {32'h0, srcbE};

  assign abs_a = (div_signed && srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
  assign abs_b = (div_signed && srcbE[31]) ? (~srcbE + 32'd1) : srcbE;

  // div_q holds the not-yet-consumed dividend bits in its top and collects quotient bits at the bottom.
  assign shifted = {div_r, div_q[31]};
  assign trial   = shifted - {1'b0, div_b};

  assign q_final = neg_q ? (~div_q + 32'd1) : div_q;
  assign r_final = neg_r ? (~div_r + 32'd1) : div_r;

  assign hi_o = hi;
  assign lo_o = lo;

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    stall_divE = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall_divE = is_div & commit;
        BUSY:    stall_divE = ~flushE;
        default: stall_divE = 1'b0;
      endcase
    end
  end

  always_comb begin
    resultE = 32'h0;
    case (alucontrolE)
      MFHI_CONTROL: resultE = hi;
      MFLO_CONTROL: resultE = lo;
      MUL_CONTROL:  resultE = prod_s[31:0];
      default:      resultE = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= HI_RST;
      lo    <= LO_RST;
      state <= IDLE;
      count <= 5'd0;
      div_q <= 32'h0;
      div_r <= 32'h0;
      div_b <= 32'h0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (commit) begin
            case (alucontrolE)
              MULT_CONTROL:  {hi, lo} <= prod_s;
              MULTU_CONTROL: {hi, lo} <= prod_u;
              MTHI_CONTROL:  hi <= srcaE;
              MTLO_CONTROL:  lo <= srcaE;
`ifdef MULDIV_MACC_EN
              MADD_CONTROL:  {hi, lo} <= {hi, lo} + prod_s;
              MADDU_CONTROL: {hi, lo} <= {hi, lo} + prod_u;
              MSUB_CONTROL:  {hi, lo} <= {hi, lo} - prod_s;
              MSUBU_CONTROL: {hi, lo} <= {hi, lo} - prod_u;
`endif
              DIV_CONTROL, DIVU_CONTROL: begin
                count <= 5'd0;
                if (srcbE == 32'h0) begin
                  // Divide by zero bypasses iteration; no sign fixup applies to these fixed results.
                  div_q <= 32'hffff_ffff;
                  div_r <= srcaE;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  state <= DONE;
                end else begin
                  div_q <= abs_a;
                  div_r <= 32'h0;
                  div_b <= abs_b;
                  neg_q <= div_signed & (srcaE[31] ^ srcbE[31]);
                  neg_r <= div_signed & srcaE[31];
                  state <= BUSY;
                end
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            if (trial[32]) begin
              div_r <= shifted[31:0];
              div_q <= {div_q[30:0], 1'b0};
            end else begin
              div_r <= trial[31:0];
              div_q <= {div_q[30:0], 1'b1};
            end
            count <= count + 5'd1;
            if (count == 5'd31) state <= DONE;
          end
        end
        DONE: begin
          if (commit) begin
            lo <= q_final;
            hi <= r_final;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: randomized ops against an arithmetic HI/LO reference model.
// Expectations follow MULDIV_MACC_EN the same way the design does.
module tb_hilo_muldiv;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] BAD   = 8'hff;
  localparam logic [7:0] MFHI  = 8'h10;
  localparam logic [7:0] MTHI  = 8'h11;
  localparam logic [7:0] MFLO  = 8'h12;
  localparam logic [7:0] MTLO  = 8'h13;
  localparam logic [7:0] MULT  = 8'h18;
  localparam logic [7:0] MULTU = 8'h19;
  localparam logic [7:0] DIV   = 8'h1a;
  localparam logic [7:0] DIVU  = 8'h1b;
  localparam logic [7:0] MUL   = 8'h1c;
  localparam logic [7:0] MADD  = 8'h20;
  localparam logic [7:0] MADDU = 8'h21;
  localparam logic [7:0] MSUB  = 8'h24;
  localparam logic [7:0] MSUBU = 8'h25;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alucontrolE;
  logic [31:0] srcaE, srcbE;
  logic        enE, flushE;
  logic        stall_divE;
  logic [31:0] resultE, hi_o, lo_o;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m, lo_m;

  hilo_muldiv #(.HI_RST(32'h0), .LO_RST(32'h0)) dut (
    .clk(clk), .rst(rst), .alucontrolE(alucontrolE), .srcaE(srcaE), .srcbE(srcbE),
    .enE(enE), .flushE(flushE), .stall_divE(stall_divE), .resultE(resultE),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic fl);
    alucontrolE = op;
    srcaE       = a;
    srcbE       = b;
    enE         = en;
    flushE      = fl;
  endtask

  // One committed single-cycle op, then back to a bubble; returns at the following negedge.
  task automatic step_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    set_in(op, a, b, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    if (b == 32'h0) begin
      q = 32'hffff_ffff;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Holds the divide in EX while stalled; counts stalled cycles. gate drops enE mid-iteration.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit gate, input bit en_done, output int n);
    @(negedge clk);
    set_in(op, a, b, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      enE = !(gate && n >= 5 && n <= 10);
      #1;
      if (!stall_divE) break;
      n++;
      @(negedge clk);
    end
    enE = en_done;
    @(posedge clk);
    @(negedge clk);
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'h0); end
    checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'h0); end
    checks++; if (stall_divE !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_divE); end
    checks++; if (resultE !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", resultE); end
    rst = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;
  endtask

  task automatic test_mult;
    logic [63:0] p;
    logic [7:0]  op;
    logic [31:0] a, b;
    step_op(MULT, 32'hffff_fffe, 32'd3);
    checks++; if ({hi_o, lo_o} !== 64'hffff_ffff_ffff_fffa) begin failures++; $display("FAIL mult_dir got=%h%h exp=ffffffff_fffffffa", hi_o, lo_o); end
    step_op(MULTU, 32'hffff_fffe, 32'd3);
    checks++; if ({hi_o, lo_o} !== 64'h0000_0002_ffff_fffa) begin failures++; $display("FAIL multu_dir got=%h%h exp=00000002_fffffffa", hi_o, lo_o); end
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MULT : MULTU;
      a  = $urandom;
      b  = $urandom;
      p  = product(op == MULT, a, b);
      step_op(op, a, b);
      hi_m = p[63:32];
      lo_m = p[31:0];
      checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL mult_rand op=%h a=%h b=%h got=%h%h exp=%h%h", op, a, b, hi_o, lo_o, hi_m, lo_m); end
    end
  endtask

  task automatic test_mul_and_moves;
    logic [63:0] p;
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      p = product(1'b1, a, b);
      @(negedge clk);
      set_in(MUL, a, b, 1'b1, 1'b0);
      #1;
      checks++; if (resultE !== p[31:0]) begin failures++; $display("FAIL mul_result a=%h b=%h got=%h exp=%h", a, b, resultE, p[31:0]); end
      @(posedge clk);
      @(negedge clk);
      set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL mul_keeps_hilo got=%h%h exp=%h%h", hi_o, lo_o, hi_m, lo_m); end
    end
    step_op(MTHI, 32'd5, $urandom);
    step_op(MTLO, 32'd6, $urandom);
    hi_m = 32'd5;
    lo_m = 32'd6;
    @(negedge clk);
    set_in(MFHI, $urandom, $urandom, 1'b1, 1'b0);
    #1;
    checks++; if (resultE !== 32'd5) begin failures++; $display("FAIL mfhi got=%h exp=%h", resultE, 32'd5); end
    @(negedge clk);
    set_in(MFLO, $urandom, $urandom, 1'b1, 1'b0);
    #1;
    checks++; if (resultE !== 32'd6) begin failures++; $display("FAIL mflo got=%h exp=%h", resultE, 32'd6); end
    @(negedge clk);
    set_in(BAD, $urandom, $urandom, 1'b1, 1'b0);
    #1;
    checks++; if (resultE !== 32'h0) begin failures++; $display("FAIL unknown_result got=%h exp=0", resultE); end
    @(posedge clk);
    @(negedge clk);
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL unknown_hilo got=%h%h exp=%h%h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  task automatic test_div;
    int n;
    logic [7:0]  op;
    logic [31:0] a, b, q, r;
    do_div(DIV, 32'hffff_fff9, 32'd2, 1'b0, 1'b1, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL div_stall_len got=%0d exp=33", n); end
    checks++; if ({hi_o, lo_o} !== 64'hffff_ffff_ffff_fffd) begin failures++; $display("FAIL div_neg7_2 got=%h%h exp=ffffffff_fffffffd", hi_o, lo_o); end
    do_div(DIVU, 32'd100, 32'd0, 1'b0, 1'b1, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL div0_stall_len got=%0d exp=1", n); end
    checks++; if ({hi_o, lo_o} !== {32'd100, 32'hffff_ffff}) begin failures++; $display("FAIL divu_by0 got=%h%h exp=00000064_ffffffff", hi_o, lo_o); end
    do_div(DIV, 32'h8000_0000, 32'hffff_ffff, 1'b0, 1'b1, n);
    checks++; if ({hi_o, lo_o} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_overflow got=%h%h exp=00000000_80000000", hi_o, lo_o); end
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
      a  = $urandom;
      b  = (i < 4) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
      if (b == 32'h0) b = 32'd3;
      if (i[0]) b = -b;
      ref_div(op == DIV, a, b, q, r);
      do_div(op, a, b, 1'b0, 1'b1, n);
      hi_m = r;
      lo_m = q;
      checks++; if (n !== 33) begin failures++; $display("FAIL div_rand_stall got=%0d exp=33", n); end
      checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL div_rand op=%h a=%h b=%h got=%h%h exp=%h%h", op, a, b, hi_o, lo_o, hi_m, lo_m); end
    end
  endtask

  task automatic test_div_enable;
    int n;
    logic [31:0] q, r;
    ref_div(1'b1, 32'hffff_fc00, 32'd7, q, r);
    do_div(DIV, 32'hffff_fc00, 32'd7, 1'b1, 1'b1, n);
    hi_m = r;
    lo_m = q;
    checks++; if (n !== 33) begin failures++; $display("FAIL en_gap_stall got=%0d exp=33", n); end
    checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL en_gap_result got=%h%h exp=%h%h", hi_o, lo_o, hi_m, lo_m); end
    do_div(DIVU, 32'd50, 32'd7, 1'b0, 1'b0, n);
    checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL done_gated got=%h%h exp=%h%h", hi_o, lo_o, hi_m, lo_m); end
    checks++; if (stall_divE !== 1'b0) begin failures++; $display("FAIL done_gated_stall got=%b exp=0", stall_divE); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    set_in(DIV, 32'd1000, 32'd3, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    checks++; if (stall_divE !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%b exp=1", stall_divE); end
    @(negedge clk);
    flushE = 1'b1;
    #1;
    checks++; if (stall_divE !== 1'b0) begin failures++; $display("FAIL flush_cycle_stall got=%b exp=0", stall_divE); end
    @(negedge clk);
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++; if (stall_divE !== 1'b0) begin failures++; $display("FAIL flush_next_stall got=%b exp=0", stall_divE); end
    repeat (40) @(negedge clk);
    checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL flush_hilo got=%h%h exp=%h%h", hi_o, lo_o, hi_m, lo_m); end
  endtask

  task automatic test_macc;
    logic [63:0] p;
    logic [7:0]  op;
    logic [31:0] a, b;
    step_op(MTHI, 32'h0, 32'h0);
    step_op(MTLO, 32'hffff_ffff, 32'h0);
    hi_m = 32'h0;
    lo_m = 32'hffff_ffff;
    step_op(MADDU, 32'd1, 32'd1);
`ifdef MULDIV_MACC_EN
    {hi_m, lo_m} = {hi_m, lo_m} + 64'd1;
`endif
    checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL maddu_dir got=%h%h exp=%h%h", hi_o, lo_o, hi_m, lo_m); end
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0: op = MADD;
        1: op = MADDU;
        2: op = MSUB;
        default: op = MSUBU;
      endcase
      a = $urandom;
      b = $urandom;
      p = product(op == MADD || op == MSUB, a, b);
      step_op(op, a, b);
`ifdef MULDIV_MACC_EN
      if (op == MADD || op == MADDU) {hi_m, lo_m} = {hi_m, lo_m} + p;
      else                           {hi_m, lo_m} = {hi_m, lo_m} - p;
`endif
      checks++; if ({hi_o, lo_o} !== {hi_m, lo_m}) begin failures++; $display("FAIL macc_rand op=%h a=%h b=%h got=%h%h exp=%h%h", op, a, b, hi_o, lo_o, hi_m, lo_m); end
    end
  endtask

  task automatic test_reset_mid_div;
    step_op(MTHI, 32'h1234, 32'h0);
    step_op(MTLO, 32'h5678, 32'h0);
    @(negedge clk);
    set_in(DIV, 32'd999, 32'd4, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({hi_o, lo_o} !== 64'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h%h exp=0", hi_o, lo_o); end
    checks++; if (stall_divE !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall_divE); end
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;
    @(negedge clk);
    set_in(MFHI, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    checks++; if (resultE !== 32'h0 || stall_divE !== 1'b0) begin failures++; $display("FAIL post_rst_mfhi got=%h stall=%b exp=0 stall=0", resultE, stall_divE); end
    @(negedge clk);
    set_in(NOP, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mul_and_moves();
    test_div();
    test_div_enable();
    test_flush();
    test_macc();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
